// File: rtl/spi_seq_pkg.sv
// Shared state encoding and counter width for the SPI configuration sequencer.
// No logic, no latency, no backpressure: types and constants only.
package spi_seq_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      GAP,
      SETTLE,
      DONE,
      ERR
   } seq_state_t;

endpackage

// File: rtl/spi_seq_dly_cnt.sv
// Loadable down-counter; done is high while the count sits at 1 (last cycle of a delay).
// Load takes priority over decrement; counting stops at zero, so it never wraps.
import spi_seq_pkg::*;

module spi_seq_dly_cnt #(
   parameter int W = CNT_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == W'(1));

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Walks config ROM 0..NUM_WORDS-1, one word_req per word, GAP_CYCLES+1 clk word_done->word_req, then settles and raises data_end.
// Paced entirely by word_done from the shifter; SPI_SEQ_TIMEOUT_EN adds a watchdog that parks in ERR if word_done never comes.
import spi_seq_pkg::*;

module spi_cfg_sequencer #(
   parameter int   NUM_WORDS     = 65,
   parameter int   ADDR_W        = 7,
   parameter int   GAP_CYCLES    = 0,
   parameter int   SETTLE_CYCLES = 7,
   parameter logic CS_PARK       = 1'b0,
   parameter int   TIMEOUT_CYC   = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              word_done,
   input  logic              cs_spi,
   output logic [ADDR_W-1:0] data_addr,
   output logic              word_req,
   output logic              cs_ad,
   output logic              busy,
   output logic              data_end,
   output logic              seq_error
);

   if (NUM_WORDS < 1) begin : g_bad_num_words
      $error("spi_cfg_sequencer: NUM_WORDS must be at least 1");
   end
   if ((1 << ADDR_W) < NUM_WORDS) begin : g_bad_addr_w
      $error("spi_cfg_sequencer: ADDR_W too narrow for NUM_WORDS");
   end
   if ((GAP_CYCLES < 0) || (GAP_CYCLES >= (1 << CNT_W))) begin : g_bad_gap
      $error("spi_cfg_sequencer: GAP_CYCLES out of counter range");
   end
   if ((SETTLE_CYCLES < 0) || (SETTLE_CYCLES >= (1 << CNT_W))) begin : g_bad_settle
      $error("spi_cfg_sequencer: SETTLE_CYCLES out of counter range");
   end
   if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC >= (1 << CNT_W))) begin : g_bad_timeout
      $error("spi_cfg_sequencer: TIMEOUT_CYC out of counter range");
   end

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   seq_state_t        state, state_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              cnt_load, cnt_dec, cnt_done;
   logic [CNT_W-1:0]  cnt_val;

   // GAP, SETTLE and the WAIT watchdog never overlap, so one counter serves all three.
   spi_seq_dly_cnt #(.W(CNT_W)) u_dly_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .done     (cnt_done)
   );

   assign cnt_dec = (state == WAIT) || (state == GAP) || (state == SETTLE);

   always_comb begin
      state_nxt = state;
      addr_nxt  = data_addr;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      case (state)
         IDLE, DONE, ERR: begin
            if (start) begin
               addr_nxt  = '0;
               state_nxt = REQ;
            end
         end
         REQ: begin
            state_nxt = WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
            cnt_load  = 1'b1;
            cnt_val   = CNT_W'(TIMEOUT_CYC);
`endif
         end
         WAIT: begin
            if (word_done) begin
               if (data_addr == LAST_ADDR) begin
                  if (SETTLE_CYCLES == 0) begin
                     state_nxt = DONE;
                  end else begin
                     state_nxt = SETTLE;
                     cnt_load  = 1'b1;
                     cnt_val   = CNT_W'(SETTLE_CYCLES);
                  end
               end else begin
                  addr_nxt = data_addr + ADDR_W'(1);
                  if (GAP_CYCLES == 0) begin
                     state_nxt = REQ;
                  end else begin
                     state_nxt = GAP;
                     cnt_load  = 1'b1;
                     cnt_val   = CNT_W'(GAP_CYCLES);
                  end
               end
`ifdef SPI_SEQ_TIMEOUT_EN
            end else if (cnt_done) begin
               state_nxt = ERR;
`endif
            end
         end
         GAP: begin
            if (cnt_done) state_nxt = REQ;
         end
         SETTLE: begin
            if (cnt_done) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         data_addr <= '0;
         word_req  <= 1'b0;
         cs_ad     <= CS_PARK;
         busy      <= 1'b0;
         data_end  <= 1'b0;
      end else begin
         state     <= state_nxt;
         data_addr <= addr_nxt;
         word_req  <= (state_nxt == REQ);
         cs_ad     <= (state_nxt == WAIT) ? cs_spi : CS_PARK;
         busy      <= (state_nxt == REQ) || (state_nxt == WAIT) ||
                      (state_nxt == GAP) || (state_nxt == SETTLE);
         data_end  <= (state_nxt == DONE);
      end
   end

`ifdef SPI_SEQ_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         seq_error <= 1'b0;
      end else begin
         seq_error <= (state_nxt == ERR);
      end
   end
`else
   assign seq_error = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Bench for spi_cfg_sequencer: two instances (no gap / 5-cycle gap, different CS park levels) checked against a timestamp model.
// Expected event times come from arithmetic on word_done times: req = done+GAP+1, data_end = last done+SETTLE+1.
module tb_spi_cfg_sequencer;

   localparam int NW     = 4;
   localparam int AW     = 3;
   localparam int SETTLE = 7;
   localparam int TMO    = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          start     [2];
   logic          word_done [2];
   logic          cs_spi    [2];
   logic [AW-1:0] data_addr [2];
   logic          word_req  [2];
   logic          cs_ad     [2];
   logic          busy      [2];
   logic          data_end  [2];
   logic          seq_error [2];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   spi_cfg_sequencer #(
      .NUM_WORDS(NW), .ADDR_W(AW), .GAP_CYCLES(0), .SETTLE_CYCLES(SETTLE),
      .CS_PARK(1'b0), .TIMEOUT_CYC(TMO)
   ) u_dut0 (
      .clock(clock), .reset(reset), .start(start[0]), .word_done(word_done[0]),
      .cs_spi(cs_spi[0]), .data_addr(data_addr[0]), .word_req(word_req[0]),
      .cs_ad(cs_ad[0]), .busy(busy[0]), .data_end(data_end[0]), .seq_error(seq_error[0])
   );

   spi_cfg_sequencer #(
      .NUM_WORDS(NW), .ADDR_W(AW), .GAP_CYCLES(5), .SETTLE_CYCLES(SETTLE),
      .CS_PARK(1'b1), .TIMEOUT_CYC(TMO)
   ) u_dut1 (
      .clock(clock), .reset(reset), .start(start[1]), .word_done(word_done[1]),
      .cs_spi(cs_spi[1]), .data_addr(data_addr[1]), .word_req(word_req[1]),
      .cs_ad(cs_ad[1]), .busy(busy[1]), .data_end(data_end[1]), .seq_error(seq_error[1])
   );

   function automatic int gap_of(input int d);
      return (d == 0) ? 0 : 5;
   endfunction

   function automatic logic park_of(input int d);
      return (d == 0) ? 1'b0 : 1'b1;
   endfunction

   // One load on instance d. fixed_dly=0 draws word_done delays at random; noise sprinkles start pulses
   // while busy (always on word_done cycles); abort_at/hang_at name a word index, -1 for none.
   task automatic run_load(input int d, input int fixed_dly, input bit noise,
                           input int abort_at, input int hang_at);
      int next_req, req_n, done_n, end_n, err_n, ndone, widx, dly;
      bit exp_req, in_wait, exp_busy, exp_end, exp_err, finished;
      logic exp_cs, prev_cs;
      logic [AW-1:0] exp_addr;
      next_req = 1; req_n = -1; done_n = -1; end_n = -1; err_n = -1;
      ndone = 0; widx = 0; finished = 0;
      @(negedge clock);
      start[d]     = 1'b1;
      word_done[d] = 1'b0;
      prev_cs      = 1'($urandom_range(0, 1));
      cs_spi[d]    = prev_cs;
      for (int n = 1; n < 600 && !finished; n++) begin
         @(negedge clock);
         exp_err  = (err_n >= 0) && (n >= err_n);
         exp_req  = (n == next_req) && (ndone < NW) && !exp_err;
         in_wait  = (req_n >= 0) && (n > req_n) && (n <= done_n) && !exp_err;
         exp_busy = !exp_err && ((end_n < 0) || (n < end_n));
         exp_end  = (end_n >= 0) && (n >= end_n);
         exp_cs   = in_wait ? prev_cs : park_of(d);
         exp_addr = AW'((ndone > NW - 1) ? NW - 1 : ndone);

         checks++;
         if (word_req[d] !== exp_req) begin
            errors++;
            $display("FAIL word_req dut%0d cyc %0d: got %b want %b", d, n, word_req[d], exp_req);
         end
         checks++;
         if (data_addr[d] !== exp_addr) begin
            errors++;
            $display("FAIL data_addr dut%0d cyc %0d: got %0d want %0d", d, n, data_addr[d], exp_addr);
         end
         checks++;
         if (busy[d] !== exp_busy) begin
            errors++;
            $display("FAIL busy dut%0d cyc %0d: got %b want %b", d, n, busy[d], exp_busy);
         end
         checks++;
         if (data_end[d] !== exp_end) begin
            errors++;
            $display("FAIL data_end dut%0d cyc %0d: got %b want %b", d, n, data_end[d], exp_end);
         end
         checks++;
         if (cs_ad[d] !== exp_cs) begin
            errors++;
            $display("FAIL cs_ad dut%0d cyc %0d: got %b want %b", d, n, cs_ad[d], exp_cs);
         end
         checks++;
         if (seq_error[d] !== exp_err) begin
            errors++;
            $display("FAIL seq_error dut%0d cyc %0d: got %b want %b", d, n, seq_error[d], exp_err);
         end

         if (exp_req) begin
            req_n  = n;
            dly    = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 5));
            done_n = (widx == hang_at) ? 32'h3fff_ffff : n + dly;
            if (widx == hang_at) err_n = n + 1 + TMO;
            widx++;
         end

         if ((abort_at == widx - 1) && (req_n >= 0) && (n == req_n + 1)) begin
            start[d]     = 1'b0;
            word_done[d] = 1'b0;
            reset        = 1'b1;
            @(negedge clock);
            checks++;
            if ({word_req[d], data_addr[d], busy[d], data_end[d], seq_error[d]} !== '0 ||
                cs_ad[d] !== park_of(d)) begin
               errors++;
               $display("FAIL abort_reset dut%0d: got req=%b addr=%0d busy=%b end=%b err=%b cs=%b want all 0, cs=%b",
                        d, word_req[d], data_addr[d], busy[d], data_end[d], seq_error[d], cs_ad[d], park_of(d));
            end
            reset    = 1'b0;
            finished = 1;
         end else begin
            word_done[d] = (n == done_n);
            start[d]     = noise && exp_busy && ((n == done_n) || ($urandom_range(0, 3) == 0));
            if (n == done_n) begin
               ndone++;
               if (ndone == NW) end_n = n + SETTLE + 1;
               else             next_req = n + gap_of(d) + 1;
            end
            prev_cs   = 1'($urandom_range(0, 1));
            cs_spi[d] = prev_cs;
            if (((end_n >= 0) && (n == end_n + 1)) || ((err_n >= 0) && (n == err_n + 1)))
               finished = 1;
         end
      end
      start[d]     = 1'b0;
      word_done[d] = 1'b0;
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL load_bound dut%0d: got unfinished want finished within 600 cycles", d);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({word_req[d], data_addr[d], busy[d], data_end[d], seq_error[d]} !== '0 ||
             cs_ad[d] !== park_of(d)) begin
            errors++;
            $display("FAIL reset_values dut%0d: got req=%b addr=%0d busy=%b end=%b err=%b cs=%b want all 0, cs=%b",
                     d, word_req[d], data_addr[d], busy[d], data_end[d], seq_error[d], cs_ad[d], park_of(d));
         end
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_basic_load();
      run_load(0, 3, 1'b0, -1, -1);
      repeat (3) @(negedge clock);
      word_done[0] = 1'b1;
      @(negedge clock);
      word_done[0] = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (data_end[0] !== 1'b1 || busy[0] !== 1'b0 || word_req[0] !== 1'b0 ||
          data_addr[0] !== AW'(NW - 1)) begin
         errors++;
         $display("FAIL done_hold: got end=%b busy=%b req=%b addr=%0d want 1 0 0 %0d",
                  data_end[0], busy[0], word_req[0], data_addr[0], NW - 1);
      end
   endtask

   task automatic test_gap();
      run_load(1, 0, 1'b0, -1, -1);
      run_load(1, 0, 1'b0, -1, -1);
   endtask

   task automatic test_start_ignored();
      run_load(0, 0, 1'b1, -1, -1);
      run_load(1, 0, 1'b1, -1, -1);
   endtask

   task automatic test_reset_abort();
      run_load(0, 0, 1'b0, 2, -1);
      run_load(0, 0, 1'b0, -1, -1);
   endtask

   task automatic test_restart_from_done();
      checks++;
      if (data_end[0] !== 1'b1) begin
         errors++;
         $display("FAIL pre_restart_end: got %b want 1", data_end[0]);
      end
      run_load(0, 0, 1'b0, -1, -1);
      run_load(1, 0, 1'b0, -1, -1);
      run_load(1, 0, 1'b1, -1, -1);
   endtask

`ifdef SPI_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      run_load(1, 0, 1'b0, -1, 1);
      run_load(1, 0, 1'b0, -1, -1);
      run_load(0, 0, 1'b0, -1, 0);
      run_load(0, 0, 1'b0, -1, -1);
   endtask
`endif

   initial begin
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start[d]     = 1'b0;
         word_done[d] = 1'b0;
         cs_spi[d]    = 1'b0;
      end
      test_reset();
      test_basic_load();
      test_gap();
      test_start_ignored();
      test_reset_abort();
      test_restart_from_done();
`ifdef SPI_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
